// File: rtl/nose_mac_pkg.sv
// Shared widths, FSM state encoding and Q16.16 constants for the NOSE
// multiply-accumulate datapath.
package nose_mac_pkg;

   localparam int unsigned PROD_W = 64;   // signed Q32.32 product
   localparam int unsigned OUT_W  = 32;   // signed Q16.16 result
   localparam int unsigned SHIFT  = 16;   // product scale -> output scale
   localparam int unsigned ACC_W  = 72;   // 8 guard bits: 256 terms cannot overflow
   localparam int unsigned CNT_W  = 9;    // term counter width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      ROUND = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam logic [OUT_W-1:0] ONE_Q16 = 32'h0001_0000;
   localparam logic [OUT_W-1:0] MAX_Q16 = 32'h7FFF_FFFF;
   localparam logic [OUT_W-1:0] MIN_Q16 = 32'h8000_0000;

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up and saturate from Q(ACC) to signed Q16.16.
// Build option: PRODUCT_ACCUMULATOR_RELU_EN clamps negative results to zero.
module round_sat
   import nose_mac_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] res,
   output logic             sat
);

   localparam int unsigned RW = ACC_W - SHIFT;

   logic [RW-1:0]        r;
   logic [RW-OUT_W:0]    hi;
   logic                 pos_ovf;
   logic                 unused_bits;

   // (acc + 2^(SHIFT-1)) >>> SHIFT == (acc >>> SHIFT) + acc[SHIFT-1]
   assign r           = acc[ACC_W-1:SHIFT] + RW'(acc[SHIFT-1]);
   assign unused_bits = ^acc[SHIFT-2:0];

   // Bits above the result sign must all match the sign for r to fit
   assign hi      = r[RW-1:OUT_W-1];
   assign pos_ovf = ~r[RW-1] & (|hi);

`ifdef PRODUCT_ACCUMULATOR_RELU_EN
   // ReLU after rounding; only positive clipping remains possible
   always_comb begin
      res = r[OUT_W-1:0];
      sat = 1'b0;
      if (r[RW-1]) begin
         res = '0;
      end else if (pos_ovf) begin
         res = MAX_Q16;
         sat = 1'b1;
      end
   end
`else
   logic neg_ovf;
   assign neg_ovf = r[RW-1] & ~(&hi);

   // Signed clip to the Q16.16 range
   always_comb begin
      res = r[OUT_W-1:0];
      sat = 1'b0;
      if (pos_ovf) begin
         res = MAX_Q16;
         sat = 1'b1;
      end else if (neg_ovf) begin
         res = MIN_Q16;
         sat = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of signed Q32.32 products into one dot-product sum,
// then rounds/saturates to Q16.16 and presents it on a valid/ready output.
// Build option: PRODUCT_ACCUMULATOR_RELU_EN (see round_sat).
module product_accumulator
   import nose_mac_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [PROD_W-1:0] p_in,
   input  logic              p_valid,
   input  logic              p_last,
   output logic              p_ready,
   output logic [OUT_W-1:0]  res_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              sat_flag,
   output logic [CNT_W-1:0]  term_count
);

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc, acc_nxt;
   logic [ACC_W-1:0]   p_sext;
   logic [OUT_W-1:0]   res_out_nxt, rs_val;
   logic               res_valid_nxt, sat_flag_nxt, rs_sat, p_ready_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               beat;

   assign p_sext = {{(ACC_W-PROD_W){p_in[PROD_W-1]}}, p_in};
   assign beat   = p_valid & p_ready;

   round_sat u_round_sat (
      .acc (acc),
      .res (rs_val),
      .sat (rs_sat)
   );

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         res_out    <= '0;
         res_valid  <= 1'b0;
         sat_flag   <= 1'b0;
         term_count <= '0;
         p_ready    <= 1'b1;
      end else begin
         state      <= state_nxt;
         acc        <= acc_nxt;
         res_out    <= res_out_nxt;
         res_valid  <= res_valid_nxt;
         sat_flag   <= sat_flag_nxt;
         term_count <= cnt_nxt;
         p_ready    <= p_ready_nxt;
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      res_out_nxt   = res_out;
      res_valid_nxt = res_valid;
      sat_flag_nxt  = sat_flag;
      cnt_nxt       = term_count;

      case (state)
         IDLE: begin
            if (beat) begin
               acc_nxt   = p_sext;
               cnt_nxt   = CNT_W'(1);
               state_nxt = p_last ? ROUND : ACC;
            end
         end
         ACC: begin
            if (beat) begin
               acc_nxt = acc + p_sext;
               if (term_count != {CNT_W{1'b1}}) cnt_nxt = term_count + CNT_W'(1);
               if (p_last) state_nxt = ROUND;
            end
         end
         ROUND: begin
            res_out_nxt   = rs_val;
            sat_flag_nxt  = rs_sat;
            res_valid_nxt = 1'b1;
            state_nxt     = OUT;
         end
         OUT: begin
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      p_ready_nxt = (state_nxt == IDLE) || (state_nxt == ACC);
   end

endmodule
